// File: rtl/sram_controller.sv
// sram_controller: ARM pipeline memory stage driving a 16-bit asynchronous SRAM.
// Each 32-bit load/store becomes a low then a high half-word phase; ready is
// held low (freezing the pipeline) until the access completes.
// Optional feature macro: SRAM_ERR_CHECK_EN (address fault detection, addr_err pulse).
module sram_controller #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        address,
  input  logic [31:0]        wr_data,
  output logic [31:0]        rd_data,
  output logic               ready,
  output logic               addr_err,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  localparam int unsigned OFF_W = SRAM_AW - 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  state_e             state_q, state_d;
  logic               we_op_q, we_op_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic [15:0]        lo_q, lo_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic               we_n_q, we_n_d;
  logic               oe_n_q, oe_n_d;
  logic               dq_oe_q, dq_oe_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic               err_q, err_d;

  logic               req_c;
  logic               last_c;
  logic               phase_c;
  logic [OFF_W-1:0]   off_c;
  logic               fault_c;

  assign req_c  = MEM_R_EN | MEM_W_EN;
  assign last_c = (cnt_q == CNT_W'(WAIT_CYCLES));
  assign off_c  = OFF_W'((address - 32'(ADDR_BASE)) >> 2);

`ifdef SRAM_ERR_CHECK_EN
  logic [31:0] span_c;
  assign span_c  = address - 32'(ADDR_BASE);
  // Misaligned, below the window, or beyond the last SRAM word
  assign fault_c = (address[1:0] != 2'b00) || (address < 32'(ADDR_BASE)) ||
                   ((span_c >> 2) >= (32'(1) << OFF_W));
  assign addr_err = err_q;
`else
  assign fault_c  = 1'b0;
  assign addr_err = 1'b0;
`endif

  // Combinational freeze: drops the same cycle a request appears
  assign ready = ~req_c | (state_q == DONE);

  assign rd_data   = rd_data_q;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  // State register and registered SRAM pins; reset aborts any access immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      we_op_q     <= 1'b0;
      off_q       <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rd_data_q   <= '0;
      lo_q        <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_op_q     <= we_op_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rd_data_q   <= rd_data_d;
      lo_q        <= lo_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
      err_q       <= err_d;
    end
  end

  // Next state, read capture, and pin values for the cycle being entered
  always_comb begin
    state_d     = state_q;
    we_op_d     = we_op_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rd_data_d   = rd_data_q;
    lo_d        = lo_q;
    sram_addr_d = sram_addr_q;
    err_d       = 1'b0;
    phase_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_c) begin
          we_op_d = MEM_W_EN;
          off_d   = off_c;
          wdata_d = wr_data;
          cnt_d   = '0;
          if (fault_c) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = LO;
          end
        end
      end
      LO: begin
        if (last_c) begin
          if (!we_op_q) lo_d = SRAM_DQ;
          cnt_d   = '0;
          state_d = HI;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      HI: begin
        if (last_c) begin
          // Both halves land together so rd_data only moves at the end of HI
          if (!we_op_q) rd_data_d = {SRAM_DQ, lo_q};
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      default: state_d = IDLE;
    endcase

    phase_c = (state_d == LO) || (state_d == HI);
    if (phase_c) sram_addr_d = {off_d, (state_d == HI)};
    // Strobe low for all but the last phase cycle, which holds data with WE_N high
    we_n_d   = ~(phase_c & we_op_d & (cnt_d != CNT_W'(WAIT_CYCLES)));
    oe_n_d   = ~(phase_c & ~we_op_d);
    dq_oe_d  = phase_c & we_op_d;
    dq_out_d = (state_d == HI) ? wdata_d[31:16] : wdata_d[15:0];
  end

endmodule

// File: tb/tb_sram_controller.sv
// Testbench for sram_controller: directed accesses against a behavioural
// asynchronous SRAM, with a scoreboard queue checked by a DONE-cycle monitor.
module tb_sram_controller;

  localparam int unsigned AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          r_en;
  logic          w_en;
  logic [31:0]   address;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;
  logic          ready;
  logic          addr_err;
  wire  [15:0]   sram_dq;
  logic [AW-1:0] sram_addr;
  logic          sram_we_n;
  logic          sram_oe_n;
  logic          sram_ce_n;
  logic          sram_ub_n;
  logic          sram_lb_n;

  sram_controller #(.ADDR_BASE(1024), .SRAM_AW(AW), .WAIT_CYCLES(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .MEM_R_EN  (r_en),
    .MEM_W_EN  (w_en),
    .address   (address),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .ready     (ready),
    .addr_err  (addr_err),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n),
    .SRAM_OE_N (sram_oe_n),
    .SRAM_CE_N (sram_ce_n),
    .SRAM_UB_N (sram_ub_n),
    .SRAM_LB_N (sram_lb_n)
  );

  always #5 clk = ~clk;

  // Behavioural async SRAM: write latched on WE_N rising, read while OE_N low
  logic [15:0] mem [0:63];
  logic [15:0] mem_rd;
  assign mem_rd  = mem[sram_addr[5:0]];
  assign sram_dq = (!sram_oe_n && sram_we_n) ? mem_rd : 16'hzzzz;
  always @(posedge sram_we_n) mem[sram_addr[5:0]] <= sram_dq;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   lat_cnt = 0;
  int   we_lo = 0;
  int   oe_lo = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Strobe activity counters, sampled mid-cycle
  always @(negedge clk) begin
    if (!sram_we_n) we_lo++;
    if (!sram_oe_n) oe_lo++;
  end

  // Monitor: counts frozen cycles, compares the response on the DONE cycle
  always @(negedge clk) begin
    if (rst && (r_en || w_en)) begin
      if (ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(ready), 32'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("rd_data",  rd_data, mon_e.rd);
          check("addr_err", 32'(addr_err), 32'(mon_e.err));
          check("latency",  32'(lat_cnt), 32'(mon_e.lat));
        end
        lat_cnt = 0;
      end else begin
        lat_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  // Issue one access (called just after a rising edge); returns just after its closing edge
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err, input logic [7:0] lat);
    int n;
    exp_q.push_back('{rd: exp_rd, err: exp_err, lat: lat});
    w_en    = we;
    r_en    = ~we;
    address = a;
    wr_data = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 50);
    check("ready_within_bound", 32'(ready), 32'(1));
    @(posedge clk);
    #1;
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int we0, oe0;

  initial begin
    rst = 1'b0; r_en = 1'b0; w_en = 1'b0; address = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Idle after reset
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("idle_ready",    32'(ready),     32'(1));
    check("idle_we_n",     32'(sram_we_n), 32'(1));
    check("idle_oe_n",     32'(sram_oe_n), 32'(1));
    check("idle_dq_z",     32'(dut.dq_oe_q), 32'(0));
    check("idle_addr",     32'(sram_addr), 32'(0));
    check("idle_rd_data",  rd_data,        32'h0);
    check("idle_addr_err", 32'(addr_err),  32'(0));
    @(posedge clk); #1;

    // Store 0x12345678 at 1024
    we0 = we_lo; oe0 = oe_lo;
    access(1'b1, 32'd1024, 32'h1234_5678, 32'h0, 1'b0, 8'd5);
    check("mem0", 32'(mem[0]), 32'h5678);
    check("mem1", 32'(mem[1]), 32'h1234);
    check("store_we_pulses", 32'(we_lo - we0), 32'd2);
    check("store_oe_pulses", 32'(oe_lo - oe0), 32'd0);

    // Load from 1024
    we0 = we_lo; oe0 = oe_lo;
    access(1'b0, 32'd1024, 32'h0, 32'h1234_5678, 1'b0, 8'd5);
    check("load_we_pulses", 32'(we_lo - we0), 32'd0);
    check("load_oe_cycles", 32'(oe_lo - oe0), 32'd4);

    // Store at 1028, then back-to-back loads
    access(1'b1, 32'd1028, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 8'd5);
    access(1'b0, 32'd1028, 32'h0, 32'hDEAD_BEEF, 1'b0, 8'd5);
    access(1'b0, 32'd1024, 32'h0, 32'h1234_5678, 1'b0, 8'd5);
    check("mem2", 32'(mem[2]), 32'hBEEF);
    check("mem3", 32'(mem[3]), 32'hDEAD);

    // Reset during the LO write phase
    w_en = 1'b1; address = 32'd1040; wr_data = 32'hCAFE_F00D;
    @(posedge clk); #2;
    check("lo_we_n_low", 32'(sram_we_n), 32'(0));
    check("lo_addr",     32'(sram_addr), 32'd8);
    @(posedge clk); #2;
    rst = 1'b0; w_en = 1'b0;
    #1;
    check("rst_we_n",    32'(sram_we_n),     32'(1));
    check("rst_oe_n",    32'(sram_oe_n),     32'(1));
    check("rst_dq_z",    32'(dut.dq_oe_q),   32'(0));
    check("rst_state",   32'(dut.state_q),   32'(0));
    check("rst_rd_data", rd_data,            32'h0);
    check("rst_addr",    32'(sram_addr),     32'(0));
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Misaligned load from 1026
    we0 = we_lo; oe0 = oe_lo;
`ifdef SRAM_ERR_CHECK_EN
    access(1'b0, 32'd1026, 32'h0, 32'h0, 1'b1, 8'd1);
    check("fault_we_pulses", 32'(we_lo - we0), 32'd0);
    check("fault_oe_cycles", 32'(oe_lo - oe0), 32'd0);
    access(1'b0, 32'd1000, 32'h0, 32'h0, 1'b1, 8'd1);
    access(1'b0, 32'd1024, 32'h0, 32'h1234_5678, 1'b0, 8'd5);
`else
    access(1'b0, 32'd1026, 32'h0, 32'h1234_5678, 1'b0, 8'd5);
    check("unaligned_oe_cycles", 32'(oe_lo - oe0), 32'd4);
`endif

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
